// File: rtl/wb_commit_unit_pkg.sv
// Shared definitions for the write-back commit unit.
// Holds the address/data widths, the exception code for interrupts, the FSM
// state encoding and the packed layout of one lane of a dual-issue bundle.
package wb_commit_unit_pkg;

    localparam int GPR_AW  = 5;
    localparam int XLEN    = 32;
    localparam int CSR_AW  = 14;
    localparam int ECODE_W = 6;

    localparam logic [ECODE_W-1:0] ECODE_INT = 6'h00;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_CSR2 = 1'b1
    } state_t;

    typedef struct packed {
        logic               valid;
        logic               rd_we;
        logic               csr_we;
        logic               excep_en;
        logic [GPR_AW-1:0]  rd_addr;
        logic [XLEN-1:0]    rd_data;
        logic [CSR_AW-1:0]  csr_addr;
        logic [XLEN-1:0]    csr_wdata;
        logic [ECODE_W-1:0] ecode;
        logic [XLEN-1:0]    pc;
    } lane_t;

endpackage

// File: rtl/wb_commit_unit_if.sv
// Memory-stage to write-back handshake carrying one dual-issue bundle.
// master: memory stage (drives in_valid and lane fields, sees in_ready)
// slave : commit unit  (sees in_valid and lane fields, drives in_ready)
// Lane 0 is the older instruction.
interface wb_commit_unit_if;
    import wb_commit_unit_pkg::*;

    logic               in_valid;
    logic               in_ready;

    logic               l0_valid;
    logic               l0_rd_we;
    logic               l0_csr_we;
    logic               l0_excep_en;
    logic [GPR_AW-1:0]  l0_rd_addr;
    logic [XLEN-1:0]    l0_rd_data;
    logic [CSR_AW-1:0]  l0_csr_addr;
    logic [XLEN-1:0]    l0_csr_wdata;
    logic [ECODE_W-1:0] l0_ecode;
    logic [XLEN-1:0]    l0_pc;

    logic               l1_valid;
    logic               l1_rd_we;
    logic               l1_csr_we;
    logic               l1_excep_en;
    logic [GPR_AW-1:0]  l1_rd_addr;
    logic [XLEN-1:0]    l1_rd_data;
    logic [CSR_AW-1:0]  l1_csr_addr;
    logic [XLEN-1:0]    l1_csr_wdata;
    logic [ECODE_W-1:0] l1_ecode;
    logic [XLEN-1:0]    l1_pc;

    modport master (
        output in_valid,
        input  in_ready,
        output l0_valid, l0_rd_we, l0_csr_we, l0_excep_en, l0_rd_addr,
               l0_rd_data, l0_csr_addr, l0_csr_wdata, l0_ecode, l0_pc,
        output l1_valid, l1_rd_we, l1_csr_we, l1_excep_en, l1_rd_addr,
               l1_rd_data, l1_csr_addr, l1_csr_wdata, l1_ecode, l1_pc
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  l0_valid, l0_rd_we, l0_csr_we, l0_excep_en, l0_rd_addr,
               l0_rd_data, l0_csr_addr, l0_csr_wdata, l0_ecode, l0_pc,
        input  l1_valid, l1_rd_we, l1_csr_we, l1_excep_en, l1_rd_addr,
               l1_rd_data, l1_csr_addr, l1_csr_wdata, l1_ecode, l1_pc
    );

endinterface

// File: rtl/wb_commit_unit_lane_gate.sv
// Per-lane commit gating.
// Inputs : lane valid, rd_we, rd_addr, csr_we, excep_en and a kill that
//          suppresses every effect of the lane in this cycle.
// Outputs: rf_we (never for x0), csr_we, excep. A lane that raises an
//          exception never writes.
module wb_lane_gate
    import wb_commit_unit_pkg::*;
(
    input  logic              valid,
    input  logic              rd_we,
    input  logic [GPR_AW-1:0] rd_addr,
    input  logic              csr_we,
    input  logic              excep_en,
    input  logic              kill,
    output logic              rf_we_g,
    output logic              csr_we_g,
    output logic              excep_g
);

    logic live;

    assign live     = valid && !kill;
    assign rf_we_g  = live && !excep_en && rd_we && (rd_addr != '0);
    assign csr_we_g = live && !excep_en && csr_we;
    assign excep_g  = live && excep_en;

endmodule

// File: rtl/wb_commit_unit.sv
// Write-back commit unit for a dual-issue pipeline.
// A bundle accepted on the handshake (bus) is registered and committed
// combinationally in the following cycle.
// Ports: clk, rst_n (async, active low); bus (slave side of the bundle
// handshake); interrupt_en_i; two register-file write ports; one CSR write
// port; exception pulse with ecode/pc; flush pulse.
//
// state | meaning
// RUN   | commit the held bundle (or lane 0 only when both lanes write CSRs)
// CSR2  | second cycle of a dual-CSR bundle: commit lane 1 only
module wb_commit_unit
    import wb_commit_unit_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    wb_commit_unit_if.slave    bus,
    input  logic               interrupt_en_i,
    output logic               rf_we0,
    output logic               rf_we1,
    output logic [GPR_AW-1:0]  rf_waddr0,
    output logic [GPR_AW-1:0]  rf_waddr1,
    output logic [XLEN-1:0]    rf_wdata0,
    output logic [XLEN-1:0]    rf_wdata1,
    output logic               csr_we,
    output logic [CSR_AW-1:0]  csr_waddr,
    output logic [XLEN-1:0]    csr_wdata,
    output logic               excep_en_o,
    output logic [ECODE_W-1:0] excep_ecode_o,
    output logic [XLEN-1:0]    excep_pc_o,
    output logic               flush_o
);

    state_t state;
    logic   bv;
    lane_t  in0, in1, b0, b1;

    logic int_take, dual_take, excep_any;
    logic kill0, kill1;
    logic g0_rf, g0_csr, g0_exc, g1_rf, g1_csr, g1_exc;

    assign in0 = '{bus.l0_valid, bus.l0_rd_we, bus.l0_csr_we, bus.l0_excep_en,
                   bus.l0_rd_addr, bus.l0_rd_data, bus.l0_csr_addr,
                   bus.l0_csr_wdata, bus.l0_ecode, bus.l0_pc};
    assign in1 = '{bus.l1_valid, bus.l1_rd_we, bus.l1_csr_we, bus.l1_excep_en,
                   bus.l1_rd_addr, bus.l1_rd_data, bus.l1_csr_addr,
                   bus.l1_csr_wdata, bus.l1_ecode, bus.l1_pc};

    // Interrupts are only taken in RUN, so the second half of a CSR split
    // ignores interrupt_en_i.
    assign int_take  = (state == ST_RUN) && bv && b0.valid && interrupt_en_i;
    assign dual_take = (state == ST_RUN) && bv && !int_take &&
                       b0.valid && b1.valid && b0.csr_we && b1.csr_we &&
                       !b0.excep_en && !b1.excep_en;

    assign kill0 = !bv || (state == ST_CSR2) || int_take;
    assign kill1 = !bv || int_take || g0_exc || dual_take;

    wb_lane_gate u_gate0 (
        .valid    (b0.valid),
        .rd_we    (b0.rd_we),
        .rd_addr  (b0.rd_addr),
        .csr_we   (b0.csr_we),
        .excep_en (b0.excep_en),
        .kill     (kill0),
        .rf_we_g  (g0_rf),
        .csr_we_g (g0_csr),
        .excep_g  (g0_exc)
    );

    wb_lane_gate u_gate1 (
        .valid    (b1.valid),
        .rd_we    (b1.rd_we),
        .rd_addr  (b1.rd_addr),
        .csr_we   (b1.csr_we),
        .excep_en (b1.excep_en),
        .kill     (kill1),
        .rf_we_g  (g1_rf),
        .csr_we_g (g1_csr),
        .excep_g  (g1_exc)
    );

    assign excep_any    = int_take || g0_exc || g1_exc;
    assign bus.in_ready = (state == ST_RUN) && !(bv && (excep_any || dual_take));

    always_comb begin
        rf_we0        = 1'b0;
        rf_we1        = g1_rf;
        rf_waddr0     = '0;
        rf_waddr1     = '0;
        rf_wdata0     = '0;
        rf_wdata1     = '0;
        csr_we        = 1'b0;
        csr_waddr     = '0;
        csr_wdata     = '0;
        excep_en_o    = excep_any;
        flush_o       = excep_any;
        excep_ecode_o = '0;
        excep_pc_o    = '0;

        // Younger lane wins a same-register write.
        if (g0_rf && !(g1_rf && (b0.rd_addr == b1.rd_addr))) begin
            rf_we0    = 1'b1;
            rf_waddr0 = b0.rd_addr;
            rf_wdata0 = b0.rd_data;
        end
        if (g1_rf) begin
            rf_waddr1 = b1.rd_addr;
            rf_wdata1 = b1.rd_data;
        end

        // At most one lane drives the CSR port; dual writes are split.
        if (g0_csr) begin
            csr_we    = 1'b1;
            csr_waddr = b0.csr_addr;
            csr_wdata = b0.csr_wdata;
        end else if (g1_csr) begin
            csr_we    = 1'b1;
            csr_waddr = b1.csr_addr;
            csr_wdata = b1.csr_wdata;
        end

        if (int_take) begin
            excep_ecode_o = ECODE_INT;
            excep_pc_o    = b0.pc;
        end else if (g0_exc) begin
            excep_ecode_o = b0.ecode;
            excep_pc_o    = b0.pc;
        end else if (g1_exc) begin
            excep_ecode_o = b1.ecode;
            excep_pc_o    = b1.pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            bv    <= 1'b0;
            b0    <= '0;
            b1    <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (dual_take) begin
                        state <= ST_CSR2;
                    end else if (bv && excep_any) begin
                        bv <= 1'b0;
                    end else begin
                        bv <= bus.in_valid;
                        if (bus.in_valid) begin
                            b0 <= in0;
                            b1 <= in1;
                        end
                    end
                end
                ST_CSR2: begin
                    state <= ST_RUN;
                    bv    <= 1'b0;
                end
                default: begin
                    state <= ST_RUN;
                    bv    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_commit_unit.sv
module tb_wb_commit_unit;

    logic        clk;
    logic        rst_n;
    logic        interrupt_en_i;
    logic        rf_we0, rf_we1;
    logic [4:0]  rf_waddr0, rf_waddr1;
    logic [31:0] rf_wdata0, rf_wdata1;
    logic        csr_we;
    logic [13:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        excep_en_o;
    logic [5:0]  excep_ecode_o;
    logic [31:0] excep_pc_o;
    logic        flush_o;

    int n_checks = 0;
    int n_fail   = 0;

    wb_commit_unit_if bus ();

    wb_commit_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .interrupt_en_i(interrupt_en_i),
        .rf_we0        (rf_we0),
        .rf_we1        (rf_we1),
        .rf_waddr0     (rf_waddr0),
        .rf_waddr1     (rf_waddr1),
        .rf_wdata0     (rf_wdata0),
        .rf_wdata1     (rf_wdata1),
        .csr_we        (csr_we),
        .csr_waddr     (csr_waddr),
        .csr_wdata     (csr_wdata),
        .excep_en_o    (excep_en_o),
        .excep_ecode_o (excep_ecode_o),
        .excep_pc_o    (excep_pc_o),
        .flush_o       (flush_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_l0(input logic v, input logic rwe, input logic [4:0] rd,
                          input logic [31:0] rdat, input logic cwe, input logic [13:0] ca,
                          input logic [31:0] cd, input logic ex, input logic [5:0] ec,
                          input logic [31:0] pc);
        bus.l0_valid = v;   bus.l0_rd_we = rwe;  bus.l0_rd_addr = rd;
        bus.l0_rd_data = rdat; bus.l0_csr_we = cwe; bus.l0_csr_addr = ca;
        bus.l0_csr_wdata = cd; bus.l0_excep_en = ex; bus.l0_ecode = ec; bus.l0_pc = pc;
    endtask

    task automatic set_l1(input logic v, input logic rwe, input logic [4:0] rd,
                          input logic [31:0] rdat, input logic cwe, input logic [13:0] ca,
                          input logic [31:0] cd, input logic ex, input logic [5:0] ec,
                          input logic [31:0] pc);
        bus.l1_valid = v;   bus.l1_rd_we = rwe;  bus.l1_rd_addr = rd;
        bus.l1_rd_data = rdat; bus.l1_csr_we = cwe; bus.l1_csr_addr = ca;
        bus.l1_csr_wdata = cd; bus.l1_excep_en = ex; bus.l1_ecode = ec; bus.l1_pc = pc;
    endtask

    // Offer the current lanes for one edge, then sample the commit cycle.
    task automatic send_bundle();
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        interrupt_en_i = 1'b0;
        bus.in_valid = 1'b0;
        set_l0(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_l1(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("rst_rf_we0", 32'(rf_we0), 0);
        chk("rst_excep", 32'(excep_en_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_csr_we", 32'(csr_we), 0);

        // basic dual commit
        @(negedge clk);
        set_l0(1, 1, 5'd3, 32'h11, 0, 0, 0, 0, 0, 32'h1C000000);
        set_l1(1, 1, 5'd4, 32'h22, 0, 0, 0, 0, 0, 32'h1C000004);
        send_bundle();
        chk("basic_we0", 32'(rf_we0), 1);
        chk("basic_addr0", 32'(rf_waddr0), 3);
        chk("basic_data0", rf_wdata0, 32'h11);
        chk("basic_we1", 32'(rf_we1), 1);
        chk("basic_addr1", 32'(rf_waddr1), 4);
        chk("basic_data1", rf_wdata1, 32'h22);
        chk("basic_ready", 32'(bus.in_ready), 1);
        step();
        chk("empty_we0", 32'(rf_we0), 0);
        chk("empty_we1", 32'(rf_we1), 0);

        // same destination
        @(negedge clk);
        set_l0(1, 1, 5'd5, 32'hA, 0, 0, 0, 0, 0, 32'h1C000010);
        set_l1(1, 1, 5'd5, 32'hB, 0, 0, 0, 0, 0, 32'h1C000014);
        send_bundle();
        chk("samerd_we0", 32'(rf_we0), 0);
        chk("samerd_we1", 32'(rf_we1), 1);
        chk("samerd_addr1", 32'(rf_waddr1), 5);
        chk("samerd_data1", rf_wdata1, 32'hB);

        // dual CSR split
        @(negedge clk);
        set_l0(1, 0, 0, 0, 1, 14'h006, 32'd1, 0, 0, 32'h1C000020);
        set_l1(1, 0, 0, 0, 1, 14'h007, 32'd2, 0, 0, 32'h1C000024);
        send_bundle();
        chk("dcsr_c1_we", 32'(csr_we), 1);
        chk("dcsr_c1_addr", 32'(csr_waddr), 32'h006);
        chk("dcsr_c1_data", csr_wdata, 1);
        chk("dcsr_c1_ready", 32'(bus.in_ready), 0);
        step();
        chk("dcsr_c2_we", 32'(csr_we), 1);
        chk("dcsr_c2_addr", 32'(csr_waddr), 32'h007);
        chk("dcsr_c2_data", csr_wdata, 2);
        chk("dcsr_c2_ready", 32'(bus.in_ready), 0);
        step();
        chk("dcsr_c3_ready", 32'(bus.in_ready), 1);
        chk("dcsr_c3_we", 32'(csr_we), 0);

        // lane 0 exception
        @(negedge clk);
        set_l0(1, 0, 0, 0, 0, 0, 0, 1, 6'h0B, 32'h1C000100);
        set_l1(1, 1, 5'd7, 32'h77, 0, 0, 0, 0, 0, 32'h1C000104);
        send_bundle();
        chk("ex0_en", 32'(excep_en_o), 1);
        chk("ex0_flush", 32'(flush_o), 1);
        chk("ex0_ecode", 32'(excep_ecode_o), 32'h0B);
        chk("ex0_pc", excep_pc_o, 32'h1C000100);
        chk("ex0_we1", 32'(rf_we1), 0);
        chk("ex0_ready", 32'(bus.in_ready), 0);
        step();
        chk("ex0_pulse_en", 32'(excep_en_o), 0);
        chk("ex0_pulse_flush", 32'(flush_o), 0);
        chk("ex0_after_ready", 32'(bus.in_ready), 1);

        // interrupt on a dual-CSR bundle
        @(negedge clk);
        set_l0(1, 0, 0, 0, 1, 14'h006, 32'd1, 0, 6'h0C, 32'h1C000200);
        set_l1(1, 0, 0, 0, 1, 14'h007, 32'd2, 0, 0, 32'h1C000204);
        interrupt_en_i = 1'b1;
        send_bundle();
        chk("int_csr_we", 32'(csr_we), 0);
        chk("int_en", 32'(excep_en_o), 1);
        chk("int_ecode", 32'(excep_ecode_o), 0);
        chk("int_pc", excep_pc_o, 32'h1C000200);
        step();
        interrupt_en_i = 1'b0;
        chk("int_no_csr2_we", 32'(csr_we), 0);
        chk("int_no_csr2_ready", 32'(bus.in_ready), 1);

        // lane 1 exception, lane 0 clean
        @(negedge clk);
        set_l0(1, 1, 5'd9, 32'h99, 0, 0, 0, 0, 0, 32'h1C000300);
        set_l1(1, 1, 5'd10, 32'hAA, 0, 0, 0, 1, 6'h03, 32'h1C000304);
        send_bundle();
        chk("ex1_we0", 32'(rf_we0), 1);
        chk("ex1_data0", rf_wdata0, 32'h99);
        chk("ex1_we1", 32'(rf_we1), 0);
        chk("ex1_ecode", 32'(excep_ecode_o), 32'h03);
        chk("ex1_pc", excep_pc_o, 32'h1C000304);

        // invalid lanes and x0 destination
        @(negedge clk);
        set_l0(1, 1, 5'd0, 32'h55, 0, 0, 0, 0, 0, 32'h1C000400);
        set_l1(0, 1, 5'd6, 32'h66, 1, 14'h010, 32'h3, 1, 6'h01, 32'h1C000404);
        send_bundle();
        chk("x0_we0", 32'(rf_we0), 0);
        chk("inval_we1", 32'(rf_we1), 0);
        chk("inval_csr", 32'(csr_we), 0);
        chk("inval_exc", 32'(excep_en_o), 0);

        // reset while in CSR2
        @(negedge clk);
        set_l0(1, 0, 0, 0, 1, 14'h006, 32'd1, 0, 0, 32'h1C000500);
        set_l1(1, 1, 5'd8, 32'h88, 1, 14'h007, 32'd2, 0, 0, 32'h1C000504);
        send_bundle();
        chk("rcsr2_c1_addr", 32'(csr_waddr), 32'h006);
        step();
        chk("rcsr2_in_csr2", 32'(bus.in_ready), 0);
        rst_n = 1'b0;
        #1;
        chk("rcsr2_csr_we", 32'(csr_we), 0);
        chk("rcsr2_rf_we1", 32'(rf_we1), 0);
        chk("rcsr2_waddr", 32'(csr_waddr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rcsr2_ready", 32'(bus.in_ready), 1);
        chk("rcsr2_no_l1", 32'(rf_we1), 0);
        chk("rcsr2_no_csr", 32'(csr_we), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_commit_unit.md
WB_COMMIT_UNIT -- requirements
Module: wb_commit_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n; the polarity and synchronicity are fixed.
REQ-002 The ports SHALL be as follows (name  direction  width  meaning):
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  memory stage offers a dual-issue bundle.
- in_ready  out  1  bundle accepted when in_valid and in_ready are both high at a clock edge.
- lN_valid, lN_rd_we, lN_csr_we, lN_excep_en  in  1 each  per lane, N=0,1; lane 0 is older.
- lN_rd_addr  in  5  destination GPR.
- lN_rd_data  in  32  GPR write data.
- lN_csr_addr  in  14  CSR number.
- lN_csr_wdata  in  32  CSR write data.
- lN_ecode  in  6  exception code.
- lN_pc  in  32  instruction PC.
- interrupt_en_i  in  1  pending interrupt from the CSR unit.
- rf_we0/rf_we1  out  1  register-file write enables.
- rf_waddr0/rf_waddr1  out  5  register-file write addresses.
- rf_wdata0/rf_wdata1  out  32  register-file write data.
- csr_we  out  1  CSR write enable.
- csr_waddr  out  14  CSR write address.
- csr_wdata  out  32  CSR write data.
- excep_en_o  out  1  exception commit pulse.
- excep_ecode_o  out  6  exception code.
- excep_pc_o  out  32  faulting PC.
- flush_o  out  1  pipeline flush pulse.

Function
REQ-003 A bundle captured at edge k SHALL be held in a bundle register and committed combinationally during cycle k+1 (latency 1).
REQ-004 The FSM SHALL have states RUN and CSR2; reset enters RUN.
REQ-005 In RUN, in_ready SHALL be 1 unless the bundle being committed raises an exception or requires CSR2.
REQ-006 In CSR2, in_ready SHALL be 0 and the bundle register SHALL hold its value.
REQ-007 Commit rules for a lane:
- a valid lane with no exception drives a GPR write only when rd_we=1 and rd_addr!=0;
- it drives csr_we when csr_we=1.
REQ-008 When both lanes write the same nonzero rd, rf_we0 SHALL be 0 and only port 1 (lane 1) SHALL write.
REQ-009 When both lanes are valid with csr_we=1 and neither excepts, the unit SHALL use two cycles:
- cycle 1 commits lane 0 only (GPR and CSR) and moves to CSR2;
- cycle 2 commits lane 1 and returns to RUN.
REQ-010 Lane 0 exception, or interrupt_en_i=1 with lane 0 valid, SHALL produce the following in the commit cycle:
- no lane 0 or lane 1 writes;
- excep_en_o=1 and flush_o=1;
- ecode = lane 0 ecode, or 6'h00 for an interrupt;
- excep_pc_o = l0_pc.
REQ-011 An interrupt SHALL take priority over a lane 0 synchronous exception.
REQ-012 Lane 1 exception with lane 0 clean SHALL commit lane 0 normally and raise excep_en_o and flush_o with lane 1's ecode and PC.
REQ-013 When a CSR2 split occurs, interrupt_en_i SHALL be sampled only in cycle 1.
REQ-014 excep_en_o and flush_o SHALL be single-cycle pulses; the bundle register SHALL be marked empty after the exception cycle.
REQ-015 An invalid lane SHALL produce no effects; a bundle with both lanes invalid SHALL commit nothing.
REQ-016 All write and exception outputs SHALL be 0 whenever no bundle is held.

Reset
REQ-017 On rst_n low, the following SHALL clear immediately (asynchronously):
- state=RUN;
- bundle-valid=0;
- all outputs 0 except in_ready.
REQ-018 in_ready SHALL be 1 after reset release.
REQ-019 Reset asserted during CSR2 SHALL discard the pending lane 1 with no writes.

Structure
REQ-020 A shared package SHALL hold:
- GPR/CSR address and data widths;
- ecode constants (INT=6'h00);
- the FSM state encoding;
- the per-lane bundle field layout.
REQ-021 One sub-module, wb_lane_gate, SHALL be instantiated twice; it computes per-lane gated rf_we, csr_we and excep from the lane fields plus a kill input.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Basic commit: lane 0 rd=3 data=0x11, lane 1 rd=4 data=0x22, no exceptions -> next cycle rf_we0=rf_we1=1 with those addresses and data, in_ready=1.
- Same destination: both lanes rd=5, data 0xA and 0xB -> rf_we0=0, rf_we1=1, rf_wdata1=0xB.
- Dual CSR: lane 0 CSR 0x006 data 1, lane 1 CSR 0x007 data 2 -> cycle 1 csr_waddr=0x006 with in_ready=0, cycle 2 csr_waddr=0x007, cycle 3 in_ready=1.
- Lane 0 exception: l0 excep ecode=0x0B pc=0x1C000100, lane 1 rd=7 -> excep_en_o=1 and flush_o=1 for one cycle, ecode 0x0B, no rf writes.
- Interrupt during dual CSR: interrupt_en_i=1 with the dual-CSR bundle -> no CSR writes, ecode 0x00, excep_pc_o = l0_pc, no CSR2 entry.
- Reset in CSR2: rst_n pulsed low in CSR2 -> all outputs 0 at once, no lane 1 write, in_ready=1 after release.
